// File: rtl/gs_div_pkg.sv
// Shared constants and state encoding for the Goldschmidt divider request sequencer.
package gs_div_pkg;

    localparam int I_BITS = 32;
    localparam int F_BITS = 40;
    localparam int T_BITS = I_BITS + F_BITS;

    // 1.0 in Q32.40
    localparam logic [T_BITS-1:0] ONE_FX = {{(I_BITS-1){1'b0}}, 1'b1, {F_BITS{1'b0}}};
    // Saturated quotient returned for a divide-by-zero
    localparam logic [T_BITS-1:0] Q_SAT  = {T_BITS{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ZERO    = 3'd1,
        ST_LAUNCH  = 3'd2,
        ST_WAIT    = 3'd3,
        ST_DELIVER = 3'd4
    } state_t;

endpackage

// File: rtl/gs_rsp_reg.sv
// One-deep valid/ready holding register for quotient, tag and error flag.
module gs_rsp_reg
    import gs_div_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [T_BITS-1:0] q_i,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic              err_i,
    input  logic              ready_i,
    output logic              canLoad_o,
    output logic              valid_o,
    output logic [T_BITS-1:0] q_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic              err_o
);

    logic              valid_q;
    logic [T_BITS-1:0] q_q;
    logic [TAG_W-1:0]  tag_q;
    logic              err_q;

    assign canLoad_o = !valid_q || ready_i;
    assign valid_o   = valid_q;
    assign q_o       = q_q;
    assign tag_o     = tag_q;
    assign err_o     = err_q;

    // Hold the response until consumed; a load in the draining cycle replaces it seamlessly.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            q_q     <= '0;
            tag_q   <= '0;
            err_q   <= 1'b0;
        end else if (load_i && canLoad_o) begin
            valid_q <= 1'b1;
            q_q     <= q_i;
            tag_q   <= tag_i;
            err_q   <= err_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/gs_div_ctrl.sv
// Request sequencer in front of the Goldschmidt divider: screens D==0,
// launches the divider by pulsing its reset, waits for done or timeout,
// and hands the result to a one-deep response register.
module gs_div_ctrl
    import gs_div_pkg::*;
#(
    parameter int TAG_W   = 4,
    parameter int RST_CYC = 2,
    parameter int MAX_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [T_BITS-1:0] req_n,
    input  logic [T_BITS-1:0] req_d,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              div_rst,
    output logic [T_BITS-1:0] div_n,
    output logic [T_BITS-1:0] div_d,
    input  logic [T_BITS-1:0] div_q,
    input  logic              div_done,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [T_BITS-1:0] rsp_q,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_err
);

    localparam int CNT_W = $clog2(MAX_CYC + RST_CYC + 1);

    state_t            state_q, state_d;
    logic [T_BITS-1:0] divN_q, divD_q;
    logic [T_BITS-1:0] resQ_q, resQ_d;
    logic              resErr_q, resErr_d;
    logic [TAG_W-1:0]  tag_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept;
    logic              launchDone;
    logic              timeout;
    logic              rspCanLoad;
    logic              rspLoad;

    assign accept     = req_valid && req_ready;
    assign launchDone = (cnt_q == CNT_W'(RST_CYC - 1));
    assign timeout    = (cnt_q == CNT_W'(MAX_CYC));
    assign div_n      = divN_q;
    assign div_d      = divD_q;

    // State register; reset abandons any launch in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing; done takes priority over a coincident timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (accept) state_d = (req_d == '0) ? ST_ZERO : ST_LAUNCH;
            ST_ZERO:    state_d = ST_DELIVER;
            ST_LAUNCH:  if (launchDone) state_d = ST_WAIT;
            ST_WAIT:    if (div_done || timeout) state_d = ST_DELIVER;
            ST_DELIVER: if (rspCanLoad) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Outputs: divider parked in reset except while running or while a result waits to be taken.
    always_comb begin
        req_ready = 1'b0;
        div_rst   = 1'b1;
        rspLoad   = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_IDLE:    req_ready = 1'b1;
                ST_WAIT:    div_rst   = 1'b0;
                ST_DELIVER: begin
                    div_rst = rspCanLoad;
                    rspLoad = rspCanLoad;
                end
                default:    ;
            endcase
        end
    end

    // Cycle counter and pending result; counter times the launch pulse, then the wait for done.
    always_comb begin
        cnt_d    = cnt_q;
        resQ_d   = resQ_q;
        resErr_d = resErr_q;
        case (state_q)
            ST_IDLE:   cnt_d = '0;
            ST_ZERO: begin
                resQ_d   = Q_SAT;
                resErr_d = 1'b1;
            end
            ST_LAUNCH: cnt_d = launchDone ? '0 : cnt_q + CNT_W'(1);
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (div_done) begin
                    resQ_d   = div_q;
                    resErr_d = 1'b0;
                end else if (timeout) begin
                    resQ_d   = '0;
                    resErr_d = 1'b1;
                end
            end
            default:   ;
        endcase
    end

    // Operand, tag and result registers; operands stay put for the whole launch.
    always_ff @(posedge clk) begin
        if (rst) begin
            divN_q   <= '0;
            divD_q   <= '0;
            tag_q    <= '0;
            resQ_q   <= '0;
            resErr_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (accept) begin
                divN_q <= req_n;
                divD_q <= req_d;
                tag_q  <= req_tag;
            end
            resQ_q   <= resQ_d;
            resErr_q <= resErr_d;
            cnt_q    <= cnt_d;
        end
    end

    gs_rsp_reg #(
        .TAG_W (TAG_W)
    ) uRspReg (
        .clk       (clk),
        .rst       (rst),
        .load_i    (rspLoad),
        .q_i       (resQ_q),
        .tag_i     (tag_q),
        .err_i     (resErr_q),
        .ready_i   (rsp_ready),
        .canLoad_o (rspCanLoad),
        .valid_o   (rsp_valid),
        .q_o       (rsp_q),
        .tag_o     (rsp_tag),
        .err_o     (rsp_err)
    );

endmodule

// File: tb/tb_gs_div_ctrl.sv
// Directed bench for gs_div_ctrl with a behavioural divider model.
module tb_gs_div_ctrl;
    import gs_div_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [T_BITS-1:0] req_n = '0;
    logic [T_BITS-1:0] req_d = '0;
    logic [3:0]        req_tag = '0;
    logic              div_rst;
    logic [T_BITS-1:0] div_n, div_d, div_q;
    logic              div_done;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [T_BITS-1:0] rsp_q;
    logic [3:0]        rsp_tag;
    logic              rsp_err;

    int testsRun  = 0;
    int failCount = 0;
    int cyc       = 0;
    int acceptCyc = 0;
    int lat, highCnt, fallLat;
    int mdlLat    = 3;

    logic [T_BITS-1:0] mDvd = '0, mDsor = '0;
    int                mCnt = 0;

    gs_div_ctrl #(.TAG_W(4), .RST_CYC(2), .MAX_CYC(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_n     (req_n),
        .req_d     (req_d),
        .req_tag   (req_tag),
        .div_rst   (div_rst),
        .div_n     (div_n),
        .div_d     (div_d),
        .div_q     (div_q),
        .div_done  (div_done),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_q     (rsp_q),
        .rsp_tag   (rsp_tag),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    // Free-running cycle count for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    // Divider model: samples operands while held in reset, raises done mdlLat cycles after release
    always @(posedge clk) begin
        if (div_rst) begin
            mCnt  <= 0;
            mDvd  <= div_n;
            mDsor <= div_d;
        end else begin
            mCnt  <= mCnt + 1;
        end
    end
    assign div_done = !div_rst && (mCnt >= mdlLat);
    assign div_q    = (mDsor == '0) ? Q_SAT
                    : T_BITS'({mDvd, {F_BITS{1'b0}}} / {{F_BITS{1'b0}}, mDsor});

    function automatic logic [127:0] fx(input int v);
        return 128'(v) << F_BITS;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] obs, input logic [127:0] exp);
        testsRun++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request and hold it until accepted
    task automatic applyStimulus(input int n, input int d, input logic [3:0] tag);
        req_valid = 1'b1;
        req_n     = T_BITS'(fx(n));
        req_d     = T_BITS'(fx(d));
        req_tag   = tag;
        for (int i = 0; i < 40 && !req_ready; i++) tick();
        if (!req_ready) checkOutput("reqReadyWait", 0, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        acceptCyc = cyc;
    endtask

    // Wait for rsp_valid, recording accept-to-valid latency and the launch pulse shape
    task automatic waitRsp(input string name);
        lat     = -1;
        highCnt = 0;
        fallLat = -1;
        for (int i = 0; i < 60; i++) begin
            if (rsp_valid) begin
                lat = cyc - acceptCyc;
                break;
            end
            if (fallLat < 0) begin
                if (div_rst) highCnt++;
                else fallLat = cyc - acceptCyc;
            end
            tick();
        end
        if (lat < 0) checkOutput({name, "RspWait"}, 0, 1);
    endtask

    task automatic drainRsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        logic holdOk;
        logic sawValid;

        // Reset state
        tick();
        tick();
        checkOutput("rstReqReady", req_ready, 0);
        checkOutput("rstDivRst", div_rst, 1);
        checkOutput("rstRspValid", rsp_valid, 0);
        checkOutput("rstDivN", div_n, 0);
        rst = 1'b0;
        tick();
        checkOutput("idleReqReady", req_ready, 1);

        // 1: 6/2 with done three cycles after release
        mdlLat = 3;
        applyStimulus(6, 2, 4'd3);
        checkOutput("t1DivN", div_n, fx(6));
        checkOutput("t1DivD", div_d, fx(2));
        checkOutput("t1ReqReadyBusy", req_ready, 0);
        waitRsp("t1");
        checkOutput("t1RstHigh", highCnt, 2);
        checkOutput("t1Fall", fallLat, 2);
        checkOutput("t1Lat", lat, 7);
        checkOutput("t1Q", rsp_q, fx(3));
        checkOutput("t1Tag", rsp_tag, 3);
        checkOutput("t1Err", rsp_err, 0);
        drainRsp();
        checkOutput("t1Drained", rsp_valid, 0);

        // 2: divide by zero never launches the divider
        applyStimulus(5, 0, 4'd7);
        waitRsp("t2");
        checkOutput("t2NoDrop", fallLat, -1);
        checkOutput("t2Lat", lat, 2);
        checkOutput("t2Q", rsp_q, 128'({T_BITS{1'b1}}));
        checkOutput("t2Tag", rsp_tag, 7);
        checkOutput("t2Err", rsp_err, 1);
        drainRsp();

        // 3: no done -> timeout declared 16 cycles after release, visible two edges later
        mdlLat = 1000;
        applyStimulus(1, 1, 4'd5);
        waitRsp("t3");
        checkOutput("t3Fall", fallLat, 2);
        checkOutput("t3Lat", lat, 20);
        checkOutput("t3Q", rsp_q, 0);
        checkOutput("t3Tag", rsp_tag, 5);
        checkOutput("t3Err", rsp_err, 1);
        drainRsp();

        // 5: done arrives exactly at the timeout count; done wins
        mdlLat = 16;
        applyStimulus(9, 3, 4'd6);
        waitRsp("t5");
        checkOutput("t5Lat", lat, 20);
        checkOutput("t5Q", rsp_q, fx(3));
        checkOutput("t5Err", rsp_err, 0);
        drainRsp();

        // 4: second result completes while the first is still held
        mdlLat = 2;
        applyStimulus(8, 2, 4'd1);
        waitRsp("t4a");
        checkOutput("t4aLat", lat, 6);
        applyStimulus(10, 5, 4'd2);
        holdOk = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (!rsp_valid || rsp_tag !== 4'd1 || rsp_q !== T_BITS'(fx(4))) holdOk = 1'b0;
            tick();
        end
        checkOutput("t4Hold", holdOk, 1);
        checkOutput("t4StallReady", req_ready, 0);
        checkOutput("t4StallDivRst", div_rst, 0);
        checkOutput("t4FirstTag", rsp_tag, 1);
        checkOutput("t4FirstQ", rsp_q, fx(4));
        rsp_ready = 1'b1;
        tick();
        checkOutput("t4SecondValid", rsp_valid, 1);
        checkOutput("t4SecondTag", rsp_tag, 2);
        checkOutput("t4SecondQ", rsp_q, fx(2));
        checkOutput("t4BackIdle", req_ready, 1);
        checkOutput("t4Relaunch", div_rst, 1);
        tick();
        rsp_ready = 1'b0;
        checkOutput("t4Empty", rsp_valid, 0);

        // 6: reset in WAIT abandons the launch
        mdlLat = 1000;
        applyStimulus(4, 1, 4'd9);
        for (int i = 0; i < 5; i++) tick();
        checkOutput("t6InWait", div_rst, 0);
        rst = 1'b1;
        tick();
        checkOutput("t6DivRst", div_rst, 1);
        checkOutput("t6DivN", div_n, 0);
        checkOutput("t6DivD", div_d, 0);
        checkOutput("t6RspValid", rsp_valid, 0);
        checkOutput("t6RspQ", rsp_q, 0);
        checkOutput("t6RspTag", rsp_tag, 0);
        checkOutput("t6RspErr", rsp_err, 0);
        checkOutput("t6ReqReady", req_ready, 0);
        rst = 1'b0;
        sawValid = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (rsp_valid) sawValid = 1'b1;
            tick();
        end
        checkOutput("t6NoRsp", sawValid, 0);
        mdlLat = 1;
        applyStimulus(12, 4, 4'd10);
        waitRsp("t6b");
        checkOutput("t6bLat", lat, 5);
        checkOutput("t6bQ", rsp_q, fx(3));
        checkOutput("t6bTag", rsp_tag, 10);
        checkOutput("t6bErr", rsp_err, 0);
        drainRsp();

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
